// File: rtl/game_pkg.sv
// game_pkg: shared game types, screen geometry and the coordinate clamp helper
// used by the sprite sequencers.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    EXPLODING = 2'd1,
    RESPAWN   = 2'd2,
    DEAD      = 2'd3
  } state_e;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 32;

  typedef logic [10:0] coord_t;

  // Saturate a signed 12-bit position into [0, hi]; motion never wraps.
  function automatic coord_t clamp_coord(input logic signed [11:0] v, input coord_t hi);
    coord_t r;
    if (v < 12'sd0) begin
      r = 11'd0;
    end else if (v > $signed({1'b0, hi})) begin
      r = hi;
    end else begin
      r = v[10:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// frame_counter: per-frame up or saturating-down counter with clear/load and
// a terminal flag raised when the count equals term_val.
module frame_counter #(
  parameter int W  = 7,
  parameter bit UP = 1'b1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         terminal
);

  logic [W-1:0] count_r;

  // Count register: clear beats load beats step; down mode holds at zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (step) begin
      if (UP) begin
        count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else if (count_r != {W{1'b0}}) begin
        count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign terminal = (count_r == term_val);

endmodule

// File: rtl/spaceship_ctrl.sv
// spaceship_ctrl: frame-locked player ship sequencer (position, lives, explosion,
// shots). Define SPACESHIP_AUTOFIRE_EN to re-arm a shot every frame fireKey is held.
module spaceship_ctrl
  import game_pkg::*;
#(
  parameter int INIT_X         = 304,
  parameter int Y_POS          = 440,
  parameter int SPEED          = 4,
  parameter int X_MAX          = SCREEN_W - SPRITE_SIZE,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 32,
  parameter int RESPAWN_FRAMES = 64,
  parameter int FIRE_COOLDOWN  = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        leftKey,
  input  logic        rightKey,
  input  logic        fireKey,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        visible,
  output logic        exploding,
  output logic        shotRequest,
  output logic [2:0]  livesLeft,
  output logic        gameOver
);

  localparam int TIMER_W = $clog2((EXPLODE_FRAMES > RESPAWN_FRAMES) ? EXPLODE_FRAMES : RESPAWN_FRAMES) + 1;
  localparam int CD_W    = $clog2(FIRE_COOLDOWN + 1);
  localparam logic signed [11:0] SPEED_S = 12'(SPEED);

  state_e state_r, state_nxt_s;
  coord_t x_r, x_nxt_s, x_move_s;
  logic signed [11:0] dx_s;
  logic [2:0] lives_r, lives_nxt_s;
  logic hit_r, hit_nxt_s, fire_pend_r, fire_pend_nxt_s, fire_d_r;
  logic fire_set_s, fire_req_s, fire_now_s;
  logic shot_r, shot_nxt_s, visible_r, visible_nxt_s;
  logic exploding_r, exploding_nxt_s, game_over_r, game_over_nxt_s;
  logic timer_clr_s, timer_step_s, timer_term_s;
  logic [TIMER_W-1:0] timer_cnt_s, timer_inc_s, timer_end_s;
  logic cd_load_s, cd_step_s, cd_ready_s;
  logic [CD_W-1:0] cd_cnt_s;

  frame_counter #(.W(TIMER_W), .UP(1'b1)) u_timer (
    .clk(clk), .resetN(resetN), .clear(timer_clr_s), .load(1'b0),
    .load_val({TIMER_W{1'b0}}), .step(timer_step_s), .term_val(timer_end_s),
    .count(timer_cnt_s), .terminal(timer_term_s)
  );

  frame_counter #(.W(CD_W), .UP(1'b0)) u_cooldown (
    .clk(clk), .resetN(resetN), .clear(1'b0), .load(cd_load_s),
    .load_val(CD_W'(FIRE_COOLDOWN)), .step(cd_step_s), .term_val({CD_W{1'b0}}),
    .count(cd_cnt_s), .terminal(cd_ready_s)
  );

  assign timer_end_s = (state_r == EXPLODING) ? TIMER_W'(EXPLODE_FRAMES - 1)
                                              : TIMER_W'(RESPAWN_FRAMES - 1);
  assign timer_inc_s = timer_cnt_s + {{(TIMER_W-1){1'b0}}, 1'b1};
  assign cd_step_s   = startOfFrame & (cd_cnt_s != {CD_W{1'b0}});

`ifdef SPACESHIP_AUTOFIRE_EN
  assign fire_set_s = (fireKey & ~fire_d_r) | (startOfFrame & fireKey);
`else
  assign fire_set_s = fireKey & ~fire_d_r;
`endif
  assign fire_req_s = fire_pend_r | fire_set_s;
  assign fire_now_s = fire_req_s & cd_ready_s;

  // Horizontal step: exactly one key moves, both or neither hold position.
  always_comb begin
    dx_s = 12'sd0;
    if (rightKey & ~leftKey) begin
      dx_s = SPEED_S;
    end else if (leftKey & ~rightKey) begin
      dx_s = -SPEED_S;
    end else begin
      dx_s = 12'sd0;
    end
    x_move_s = clamp_coord($signed({1'b0, x_r}) + dx_s, coord_t'(X_MAX));
  end

  // Life-cycle FSM; every state change is gated by the frame strobe.
  always_comb begin
    state_nxt_s     = state_r;
    x_nxt_s         = x_r;
    lives_nxt_s     = lives_r;
    hit_nxt_s       = hit_r | (collision & (state_r == ALIVE));
    fire_pend_nxt_s = fire_req_s;
    shot_nxt_s      = 1'b0;
    visible_nxt_s   = visible_r;
    exploding_nxt_s = exploding_r;
    game_over_nxt_s = game_over_r;
    timer_clr_s     = 1'b0;
    timer_step_s    = 1'b0;
    cd_load_s       = 1'b0;
    if (startOfFrame) begin
      hit_nxt_s = 1'b0;
      case (state_r)
        ALIVE: begin
          if (hit_r | collision) begin
            lives_nxt_s     = lives_r - 3'd1;
            state_nxt_s     = EXPLODING;
            timer_clr_s     = 1'b1;
            fire_pend_nxt_s = 1'b0;
            exploding_nxt_s = 1'b1;
            visible_nxt_s   = 1'b1;
          end else begin
            x_nxt_s = x_move_s;
            if (fire_now_s) begin
              shot_nxt_s      = 1'b1;
              cd_load_s       = 1'b1;
              fire_pend_nxt_s = 1'b0;
            end else begin
              fire_pend_nxt_s = fire_req_s;
            end
          end
        end
        EXPLODING: begin
          if (timer_term_s) begin
            exploding_nxt_s = 1'b0;
            timer_clr_s     = 1'b1;
            if (lives_r == 3'd0) begin
              state_nxt_s     = DEAD;
              visible_nxt_s   = 1'b0;
              game_over_nxt_s = 1'b1;
            end else begin
              state_nxt_s   = RESPAWN;
              x_nxt_s       = coord_t'(INIT_X);
              visible_nxt_s = 1'b0;
            end
          end else begin
            timer_step_s = 1'b1;
          end
        end
        RESPAWN: begin
          x_nxt_s = x_move_s;
          if (fire_now_s) begin
            shot_nxt_s      = 1'b1;
            cd_load_s       = 1'b1;
            fire_pend_nxt_s = 1'b0;
          end else begin
            fire_pend_nxt_s = fire_req_s;
          end
          if (timer_term_s) begin
            state_nxt_s   = ALIVE;
            visible_nxt_s = 1'b1;
            timer_clr_s   = 1'b1;
          end else begin
            timer_step_s  = 1'b1;
            visible_nxt_s = timer_inc_s[2];
          end
        end
        DEAD: begin
          state_nxt_s = DEAD;
        end
        default: begin
          state_nxt_s = ALIVE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= ALIVE;
      x_r         <= coord_t'(INIT_X);
      lives_r     <= 3'(LIVES);
      hit_r       <= 1'b0;
      fire_pend_r <= 1'b0;
      fire_d_r    <= 1'b0;
      shot_r      <= 1'b0;
      visible_r   <= 1'b1;
      exploding_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      x_r         <= x_nxt_s;
      lives_r     <= lives_nxt_s;
      hit_r       <= hit_nxt_s;
      fire_pend_r <= fire_pend_nxt_s;
      fire_d_r    <= fireKey;
      shot_r      <= shot_nxt_s;
      visible_r   <= visible_nxt_s;
      exploding_r <= exploding_nxt_s;
      game_over_r <= game_over_nxt_s;
    end
  end

  assign topLeftX    = x_r;
  assign topLeftY    = 11'(Y_POS);
  assign visible     = visible_r;
  assign exploding   = exploding_r;
  assign shotRequest = shot_r;
  assign livesLeft   = lives_r;
  assign gameOver    = game_over_r;

endmodule

// File: tb/tb_spaceship_ctrl.sv
// tb_spaceship_ctrl: directed table, corner sequences and randomized frames
// checked against a frame-level behavioural model of the spaceship.
module tb_spaceship_ctrl;

  localparam int INIT_X = 304;
  localparam int Y_POS = 440;
  localparam int SPEED = 4;
  localparam int X_MAX = 608;
  localparam int LIVES = 3;
  localparam int EXPLODE_FRAMES = 32;
  localparam int RESPAWN_FRAMES = 64;
  localparam int FIRE_COOLDOWN = 16;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0, leftKey = 1'b0, rightKey = 1'b0, fireKey = 1'b0, collision = 1'b0;
  logic [10:0] topLeftX, topLeftY;
  logic visible, exploding, shotRequest, gameOver;
  logic [2:0] livesLeft;

  spaceship_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .leftKey(leftKey), .rightKey(rightKey), .fireKey(fireKey), .collision(collision),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .visible(visible), .exploding(exploding),
    .shotRequest(shotRequest), .livesLeft(livesLeft), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int shot_cycles = 0;
  int frame_no = 0;
  bit last_shot_a = 1'b0;

  // Frame-level reference model: ship phase, frames spent in it, cooldown.
  typedef enum int {M_ALIVE, M_EXPL, M_RESP, M_DEAD} mstate_t;
  mstate_t m_state;
  int m_x, m_lives, m_phase, m_cool;
  bit m_fpend, m_hit, m_flvl, m_shot;

  typedef struct {
    bit l; bit r; bit f;
    int exp_x; bit exp_shot;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_ALIVE; m_x = INIT_X; m_lives = LIVES; m_phase = 0; m_cool = 0;
    m_fpend = 1'b0; m_hit = 1'b0; m_flvl = 1'b0; m_shot = 1'b0;
  endtask

  function automatic int m_visible();
    case (m_state)
      M_ALIVE, M_EXPL: return 1;
      M_RESP:          return (m_phase / 4) % 2;
      default:         return 0;
    endcase
  endfunction

  task automatic model_sof(input bit l, input bit r, input bit c);
    int nx;
    int cool_n;
    bit fire_ok;
    cool_n = (m_cool > 0) ? m_cool - 1 : 0;
    m_shot = 1'b0;
`ifdef SPACESHIP_AUTOFIRE_EN
    if (m_flvl) m_fpend = 1'b1;
`endif
    nx = m_x + ((r && !l) ? SPEED : 0) - ((l && !r) ? SPEED : 0);
    nx = (nx < 0) ? 0 : ((nx > X_MAX) ? X_MAX : nx);
    fire_ok = m_fpend && (m_cool == 0);
    case (m_state)
      M_ALIVE: begin
        if (m_hit || c) begin
          m_lives--; m_state = M_EXPL; m_phase = 0; m_fpend = 1'b0;
        end else begin
          m_x = nx;
          if (fire_ok) begin m_shot = 1'b1; m_fpend = 1'b0; end
        end
      end
      M_EXPL: begin
        m_phase++;
        if (m_phase == EXPLODE_FRAMES) begin
          m_phase = 0;
          if (m_lives == 0) m_state = M_DEAD;
          else begin m_state = M_RESP; m_x = INIT_X; end
        end
      end
      M_RESP: begin
        m_x = nx;
        if (fire_ok) begin m_shot = 1'b1; m_fpend = 1'b0; end
        m_phase++;
        if (m_phase == RESPAWN_FRAMES) begin m_state = M_ALIVE; m_phase = 0; end
      end
      default: ;
    endcase
    m_hit = 1'b0;
    m_cool = m_shot ? FIRE_COOLDOWN : cool_n;
  endtask

  // One 4-cycle frame: strobe, then mid-frame fire level and collision pulse.
  task automatic frame(input bit l, input bit r, input bit f, input bit c_mid, input bit c_sof);
    leftKey = l; rightKey = r; startOfFrame = 1'b1; collision = c_sof;
    @(posedge clk);
    model_sof(l, r, c_sof);
    #1;
    frame_no++;
    last_shot_a = shotRequest;
    if (shotRequest) shot_cycles++;
    check("topLeftX", topLeftX, m_x);
    check("topLeftY", topLeftY, Y_POS);
    check("visible", visible, m_visible());
    check("exploding", exploding, int'(m_state == M_EXPL));
    check("shotRequest", shotRequest, m_shot);
    check("livesLeft", livesLeft, m_lives);
    check("gameOver", gameOver, int'(m_state == M_DEAD));
    startOfFrame = 1'b0; collision = c_mid; fireKey = f;
    @(posedge clk);
    if (f && !m_flvl) m_fpend = 1'b1;
    m_flvl = f;
    if (c_mid && m_state == M_ALIVE) m_hit = 1'b1;
    #1;
    collision = 1'b0;
    check("shot_width", shotRequest, 0);
    if (shotRequest) shot_cycles++;
    repeat (2) begin
      @(posedge clk); #1;
      if (shotRequest) shot_cycles++;
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0; startOfFrame = 1'b0; leftKey = 1'b0; rightKey = 1'b0;
    fireKey = 1'b0; collision = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("rst_x", topLeftX, INIT_X);
    check("rst_visible", visible, 1);
    check("rst_exploding", exploding, 0);
    check("rst_shot", shotRequest, 0);
    check("rst_lives", livesLeft, LIVES);
    check("rst_gameover", gameOver, 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    shot_cycles = 0; frame_no = 0;
  endtask

  initial begin
    int s1, s2, xb;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 308, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 312, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 308, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 308, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 308, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 312, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 316, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 320, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 324, 1'b0};

    do_reset();
    foreach (tbl[i]) begin
      frame(tbl[i].l, tbl[i].r, tbl[i].f, 1'b0, 1'b0);
      check("tbl_x", topLeftX, tbl[i].exp_x);
      check("tbl_shot", last_shot_a, tbl[i].exp_shot);
    end

    // Four fire presses in 7 frames: two one-cycle shots 17 frames apart.
    do_reset();
    s1 = -1; s2 = -1;
    for (int i = 0; i < 40; i++) begin
      frame(1'b0, 1'b0, (i == 0 || i == 2 || i == 4 || i == 6), 1'b0, 1'b0);
      if (last_shot_a) begin
        if (s1 < 0) s1 = i; else if (s2 < 0) s2 = i;
      end
    end
    check("fire_pulses", shot_cycles, 2);
    check("fire_gap", s2 - s1, FIRE_COOLDOWN + 1);

    // Edge saturation and both-keys hold.
    do_reset();
    repeat (200) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_right", topLeftX, X_MAX);
    repeat (200) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_left", topLeftX, 0);
    repeat (10) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("both_keys", topLeftX, 40);

    // Hit, explosion, blinking respawn with ignored collision, then alive.
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hit_lives", livesLeft, 2);
    check("hit_exploding", exploding, 1);
    repeat (EXPLODE_FRAMES - 1) frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("expl_last", exploding, 1);
    frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("respawn_x", topLeftX, INIT_X);
    check("respawn_expl", exploding, 0);
    check("respawn_vis0", visible, 0);
    repeat (4) frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("respawn_vis1", visible, 1);
    check("respawn_lives", livesLeft, 2);
    repeat (RESPAWN_FRAMES - 5) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("alive_vis", visible, 1);
    repeat (4) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("alive_vis_steady", visible, 1);

    // Two more hits lead to game over; input is ignored afterwards.
    frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (EXPLODE_FRAMES + RESPAWN_FRAMES + 2) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("two_hits_lives", livesLeft, 1);
    frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (EXPLODE_FRAMES + 1) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dead_visible", visible, 0);
    check("dead_gameover", gameOver, 1);
    check("dead_lives", livesLeft, 0);
    xb = topLeftX; shot_cycles = 0;
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b1, i[0], 1'b0, 1'b0);
    check("dead_x", topLeftX, xb);
    check("dead_shots", shot_cycles, 0);

    // Collision coinciding with the strobe is consumed in that frame.
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sof_hit_lives", livesLeft, 2);
    check("sof_hit_expl", exploding, 1);

    // Reset in the middle of an explosion.
    repeat (5) frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    check("midrst_x", topLeftX, 304);
    check("midrst_lives", livesLeft, 3);
    check("midrst_expl", exploding, 0);
    check("midrst_over", gameOver, 0);

    // Randomized frames against the model, with periodic resets.
    for (int i = 0; i < 800; i++) begin
      if (i % 250 == 249) do_reset();
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 99) == 0));
    end

    // Held fire key for 50 frames.
    do_reset();
    repeat (50) frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SPACESHIP_AUTOFIRE_EN
    check("autofire_shots", shot_cycles, 3);
`else
    check("held_fire_shots", shot_cycles, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
